// File: rtl/sha3_block_padder.sv
`default_nettype none
// ============================================================================
// Module   : sha3_block_padder
// Purpose  : Packs 64-bit message words into 576-bit Keccak-512 rate blocks
//            and applies multi-rate padding (0x01 ... 0x80) to the final
//            block. Each completed block is presented to the permutation
//            engine and held until it is acknowledged.
// Ports    : clk         - clock
//            reset_n     - asynchronous active-low reset
//            in          - message word, first byte in in[63:56]
//            in_ready    - in is valid this cycle
//            is_last     - in is the final word of the message
//            byte_num    - valid bytes in the final word (0..7)
//            buffer_full - padder cannot accept a word this cycle
//            out         - rate block, word 0 in out[575:512]
//            out_ready   - out holds a complete block
//            out_last    - out is the final, padded block
//            f_ack       - permutation engine consumed out
// Revision : 1.0 - initial release
// ============================================================================
module sha3_block_padder #(
    parameter int WORDS = 9
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [63:0]           in,
    input  logic                  in_ready,
    input  logic                  is_last,
    input  logic [2:0]            byte_num,
    output logic                  buffer_full,
    output logic [64*WORDS-1:0]   out,
    output logic                  out_ready,
    output logic                  out_last,
    input  logic                  f_ack
);

    localparam logic [1:0] c_ST_ACCEPT = 2'd0;
    localparam logic [1:0] c_ST_PAD    = 2'd1;
    localparam logic [1:0] c_ST_FULL   = 2'd2;

    localparam logic [3:0]  c_LAST_SLOT  = 4'(WORDS - 1);
    localparam logic [63:0] c_ALL_ONES   = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] c_PAD_FIRST  = 64'h0100_0000_0000_0000;
    localparam logic [63:0] c_PAD_FINAL  = 64'h0000_0000_0000_0080;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [3:0]            r_cnt;
    logic [64*WORDS-1:0]   r_out;
    logic                  r_out_last;

    logic                  w_slot_is_final;
    logic                  w_slot_we;
    logic [63:0]           w_slot_data;
    logic [63:0]           w_keep_mask;
    logic [63:0]           w_last_word;

    assign w_slot_is_final = (r_cnt == c_LAST_SLOT);

    // Final word: keep the leading byte_num bytes, place the 0x01 pad byte
    // right after them, and if this is also the last slot of the block fold
    // in the closing 0x80 (giving 0x81 when byte_num is 7).
    assign w_keep_mask = ~(c_ALL_ONES >> {byte_num, 3'b000});
    assign w_last_word = (in & w_keep_mask)
                       | (c_PAD_FIRST >> {byte_num, 3'b000})
                       | (w_slot_is_final ? c_PAD_FINAL : 64'd0);

    // Slot write source: accepted words in ACCEPT, zero fill in PAD with the
    // closing 0x80 landing in the last slot.
    always_comb begin
        w_slot_we   = 1'b0;
        w_slot_data = 64'd0;
        case (r_state)
            c_ST_ACCEPT: begin
                w_slot_we   = in_ready;
                w_slot_data = is_last ? w_last_word : in;
            end
            c_ST_PAD: begin
                w_slot_we   = 1'b1;
                w_slot_data = w_slot_is_final ? c_PAD_FINAL : 64'd0;
            end
            default: begin
                w_slot_we   = 1'b0;
                w_slot_data = 64'd0;
            end
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_ACCEPT: begin
                if (in_ready) begin
                    if (w_slot_is_final) begin
                        w_state_nxt = c_ST_FULL;
                    end else if (is_last) begin
                        w_state_nxt = c_ST_PAD;
                    end
                end
            end
            c_ST_PAD: begin
                if (w_slot_is_final) begin
                    w_state_nxt = c_ST_FULL;
                end
            end
            c_ST_FULL: begin
                if (f_ack) begin
                    w_state_nxt = c_ST_ACCEPT;
                end
            end
            default: w_state_nxt = c_ST_ACCEPT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_ST_ACCEPT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt      <= 4'd0;
            r_out      <= '0;
            r_out_last <= 1'b0;
        end else begin
            if (w_slot_we) begin
                for (int i = 0; i < WORDS; i++) begin
                    if (r_cnt == 4'(i)) begin
                        r_out[(WORDS-1-i)*64 +: 64] <= w_slot_data;
                    end
                end
                r_cnt <= r_cnt + 4'd1;
                // The block becomes the message's final block when its last
                // slot is filled by padding or by the is_last word itself.
                if (w_slot_is_final && ((r_state == c_ST_PAD) || is_last)) begin
                    r_out_last <= 1'b1;
                end
            end else if ((r_state == c_ST_FULL) && f_ack) begin
                r_cnt      <= 4'd0;
                r_out_last <= 1'b0;
            end
        end
    end

    assign buffer_full = (r_state != c_ST_ACCEPT);
    assign out_ready   = (r_state == c_ST_FULL);
    assign out         = r_out;
    assign out_last    = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_sha3_block_padder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha3_block_padder
// Purpose  : Directed self-checking bench for sha3_block_padder with
//            hand-computed expected rate blocks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sha3_block_padder;

    logic          clk;
    logic          reset_n;
    logic [63:0]   in;
    logic          in_ready;
    logic          is_last;
    logic [2:0]    byte_num;
    logic          buffer_full;
    logic [575:0]  out;
    logic          out_ready;
    logic          out_last;
    logic          f_ack;

    int            n_tests;
    int            n_fail;
    int            cycles;
    logic [63:0]   ew [0:8];
    logic [575:0]  held_blk;

    sha3_block_padder #(.WORDS(9)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in          (in),
        .in_ready    (in_ready),
        .is_last     (is_last),
        .byte_num    (byte_num),
        .buffer_full (buffer_full),
        .out         (out),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .f_ack       (f_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [575:0] obs, input logic [575:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [575:0] pack_blk();
        logic [575:0] b;
        b = '0;
        for (int i = 0; i < 9; i++) b[(8-i)*64 +: 64] = ew[i];
        return b;
    endfunction

    task automatic clear_exp();
        for (int i = 0; i < 9; i++) ew[i] = 64'd0;
    endtask

    // One word presented for exactly one rising edge.
    task automatic drive(input logic [63:0] w, input logic last, input logic [2:0] bn);
        @(negedge clk);
        in       = w;
        in_ready = 1'b1;
        is_last  = last;
        byte_num = bn;
        @(posedge clk);
        #1;
        in_ready = 1'b0;
        is_last  = 1'b0;
    endtask

    // Counts edges until out_ready, bounded.
    task automatic wait_ready(input int max_cycles, output int n);
        n = 0;
        while (!out_ready && n < max_cycles) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic ack();
        @(negedge clk);
        f_ack = 1'b1;
        @(posedge clk);
        #1;
        f_ack = 1'b0;
        check("ack_out_ready", {575'd0, out_ready}, 576'd0);
        check("ack_buffer_full", {575'd0, buffer_full}, 576'd0);
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        in       = 64'd0;
        in_ready = 1'b0;
        is_last  = 1'b0;
        byte_num = 3'd0;
        f_ack    = 1'b0;

        // 1. Reset
        repeat (2) @(posedge clk);
        #1;
        check("rst_out", out, 576'd0);
        check("rst_flags", {573'd0, out_ready, out_last, buffer_full}, 576'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel_buffer_full", {575'd0, buffer_full}, 576'd0);

        // 2. "a"
        drive(64'h6100_0000_0000_0000, 1'b1, 3'd1);
        check("a_busy", {575'd0, buffer_full}, 576'd1);
        wait_ready(20, cycles);
        check("a_latency", 576'(cycles), 576'd8);
        clear_exp();
        ew[0] = 64'h6101_0000_0000_0000;
        ew[8] = 64'h0000_0000_0000_0080;
        check("a_block", out, pack_blk());
        check("a_last", {575'd0, out_last}, 576'd1);
        ack();

        // 3. "abcdefgh" + empty last word (masked input bytes must vanish)
        drive(64'h6162_6364_6566_6768, 1'b0, 3'd5);
        drive(64'hDEAD_BEEF_DEAD_BEEF, 1'b1, 3'd0);
        wait_ready(20, cycles);
        check("b8_latency", 576'(cycles), 576'd7);
        clear_exp();
        ew[0] = 64'h6162_6364_6566_6768;
        ew[1] = 64'h0100_0000_0000_0000;
        ew[8] = 64'h0000_0000_0000_0080;
        check("b8_block", out, pack_blk());
        check("b8_last", {575'd0, out_last}, 576'd1);
        ack();

        // 4. 71 bytes: 0x81 combined pad byte, no PAD cycles
        clear_exp();
        for (int i = 0; i < 8; i++) begin
            ew[i] = 64'h0101_0101_0101_0101 * 64'(i + 1);
            drive(ew[i], 1'b0, 3'd0);
        end
        drive(64'hA1A2_A3A4_A5A6_A7FF, 1'b1, 3'd7);
        check("b71_ready_now", {575'd0, out_ready}, 576'd1);
        ew[8] = 64'hA1A2_A3A4_A5A6_A781;
        check("b71_block", out, pack_blk());
        check("b71_last", {575'd0, out_last}, 576'd1);
        ack();

        // 5. 72 bytes: full block, then a padding-only block
        clear_exp();
        for (int i = 0; i < 9; i++) begin
            ew[i] = 64'h1000_0000_0000_0001 + 64'(i * 3);
            drive(ew[i], 1'b0, 3'd0);
        end
        check("b72_ready_now", {575'd0, out_ready}, 576'd1);
        check("b72_block1", out, pack_blk());
        check("b72_last1", {575'd0, out_last}, 576'd0);
        ack();
        drive(64'h5555_5555_5555_5555, 1'b1, 3'd0);
        wait_ready(20, cycles);
        check("b72_latency2", 576'(cycles), 576'd8);
        clear_exp();
        ew[0] = 64'h0100_0000_0000_0000;
        ew[8] = 64'h0000_0000_0000_0080;
        check("b72_block2", out, pack_blk());
        check("b72_last2", {575'd0, out_last}, 576'd1);
        ack();

        // 6a. Backpressure: held word ignored during FULL, lands after f_ack
        clear_exp();
        for (int i = 0; i < 9; i++) begin
            ew[i] = {32'hB0B0_0000, 32'(i)};
            drive(ew[i], 1'b0, 3'd0);
        end
        held_blk = pack_blk();
        @(negedge clk);
        in       = 64'hCAFE_F00D_1234_5678;
        in_ready = 1'b1;
        is_last  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold_out", out, held_blk);
        end
        check("bp_still_full", {574'd0, out_ready, buffer_full}, 576'd3);
        @(negedge clk);
        f_ack = 1'b1;
        @(posedge clk);
        #1;
        f_ack = 1'b0;
        check("bp_ack_flags", {574'd0, out_ready, buffer_full}, 576'd0);
        check("bp_slot0_before", {512'd0, out[575:512]}, {512'd0, ew[0]});
        @(posedge clk);
        #1;
        in_ready = 1'b0;
        check("bp_slot0_after", {512'd0, out[575:512]}, {512'd0, 64'hCAFE_F00D_1234_5678});

        // 6b. Asynchronous reset in the middle of PAD
        drive(64'h7777_7777_7777_7777, 1'b1, 3'd3);
        @(posedge clk);
        #1;
        check("pad_busy", {575'd0, buffer_full}, 576'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_out", out, 576'd0);
        check("arst_flags", {573'd0, out_ready, out_last, buffer_full}, 576'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Partial block was discarded: next message starts at slot 0
        drive(64'h6100_0000_0000_0000, 1'b1, 3'd1);
        wait_ready(20, cycles);
        check("post_rst_latency", 576'(cycles), 576'd8);
        clear_exp();
        ew[0] = 64'h6101_0000_0000_0000;
        ew[8] = 64'h0000_0000_0000_0080;
        check("post_rst_block", out, pack_blk());
        ack();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
